shift_acc_mc: RTL and testbench
===============================

Name: shift_acc_mc

Overview:
Parametrised multi-slot fixed-point shift-accumulator, successor to the single-configuration shift/accumulate path in the fixp_acc block. Each input beat carries an unsigned magnitude, a left-shift amount, a sign and a slot index. The magnitude is shifted and then added to, or subtracted from, one of DEPTH signed accumulators. A clear command drains one slot to a result stream and zeroes it, with optional saturation and per-slot sticky overflow.

Parameters:
IN_WIDTH, 64, unsigned input magnitude width
ACC_WIDTH, 128, signed two's-complement accumulator width
SHIFT_W, 8, shift-amount width
DEPTH, 32, number of accumulator slots (≥2)
SATURATE, 0, 1 = clamp on signed overflow; 0 = wrap
SLOT_W, $clog2(DEPTH), derived slot index width (localparam)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
in_tvalid  in  1  input beat valid
in_tready  out  1  input beat ready
in_tdata  in  IN_WIDTH  unsigned magnitude
in_shift  in  SHIFT_W  left-shift amount
in_sign  in  1  0 = add, 1 = subtract
in_slot  in  SLOT_W  target slot
clr_valid  in  1  clear request
clr_ready  out  1  clear accepted when high with clr_valid
clr_slot  in  SLOT_W  slot to drain
add_valid  out  1  one-cycle pulse per committed accumulate
res_tvalid  out  1  result valid
res_tready  in  1  result consumer ready
res_tdata  out  ACC_WIDTH  drained slot value
res_tuser  out  SLOT_W  drained slot index
res_ovf  out  1  sticky overflow flag of the drained slot

Behaviour:
- Reset (rstn low, async): all slots = 0; ovf flags = 0; pipeline valids = 0; in_tready = 0; clr_ready = 0; add_valid = 0; res_tvalid = 0; res_tdata/res_tuser/res_ovf = 0. in_tready rises on the first clk edge after release. Reset mid-operation discards in-flight beats and any pending result.
- Pipeline: S1 register (shift stage) → S2 (read-modify-write of the slot register array in one cycle). Beat accepted at edge t is shifted at t+1 and committed at edge t+2; add_valid is high during the cycle before the commit edge. No backpressure on the add path: in_tready = 1 out of reset.
- Shift: zero-extend in_tdata to ACC_WIDTH, then shift left by in_shift. shift_ovf = 1 if any nonzero bit falls at or above bit ACC_WIDTH-1 (this includes in_shift ≥ ACC_WIDTH with nonzero data). Shifted value is truncated to ACC_WIDTH bits.
- Accumulate: sum = acc ± shifted, computed at ACC_WIDTH+1 bits. Signed overflow or shift_ovf sets the slot's sticky ovf.
  - SATURATE=1: on overflow, clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), following the operation direction.
  - SATURATE=0: wrap.
- Clear handshake: clr_ready = rstn_q AND no valid S1/S2 entry targeting clr_slot AND (res_tvalid == 0 OR res_tready == 1).
  - On accept: res_tdata ← slot value, res_tuser ← clr_slot, res_ovf ← slot ovf; res_tvalid = 1 next cycle; slot and ovf are zeroed at the same edge.
  - An input beat to the same slot accepted in the same cycle is ordered after the clear and lands in the zeroed slot.
  - An S2 commit to a different slot in the same cycle proceeds unaffected.
- Result: res_tvalid, res_tdata, res_tuser and res_ovf hold stable until res_tready. Back-to-back clears are allowed when res_tready = 1.
- Slot index ≥ DEPTH (non-power-of-2 DEPTH): the beat is dropped, no add_valid. A clear of such a slot returns 0 with res_ovf = 1.

Decomposition:
- Package shift_acc_pkg: default widths, SLOT_W computation helper (clog2), saturation constants ACC_MAX/ACC_MIN as functions of ACC_WIDTH.
- Sub-module acc_shift_stage: registered barrel shifter plus shift_ovf detection (S1).
- Top module holds S2, the slot array, the ovf flags, clear arbitration and the result register.

Test Plan:
- Slot 3: add 5 shift 4, then subtract 3 shift 0, then clear slot 3 → res_tdata = 77, res_tuser = 3, res_ovf = 0; a second clear of slot 3 returns 0.
- Hazard: add 1 to slot 5 at cycle t, assert clr_slot = 5 at t+1 → clr_ready low for t+1..t+2, accepted at t+3, result = 1.
- SATURATE=1, ACC_WIDTH=128: add 1 shift 126 twice → clear returns 2^127-1, res_ovf = 1. SATURATE=0 with the same stimulus → returns -2^127, res_ovf = 1.
- in_shift = 200, in_tdata = 1 → slot unchanged, ovf = 1. in_tdata = 0, shift 200 → no ovf.
- res_tready held 0 after a clear: a second clear stalls (clr_ready = 0) and res_* stay stable; raise res_tready → second clear accepted that cycle.
- Assert rstn low for 1 cycle with beats in S1/S2 and res_tvalid = 1 → all outputs 0 immediately; subsequent clear of any slot returns 0.

Source files
------------

// File: rtl/shift_acc_pkg.sv
// shift_acc_pkg: shared defaults, slot-width helper and saturation limits for shift_acc_mc
package shift_acc_pkg;

    localparam int DEF_IN_WIDTH  = 64;
    localparam int DEF_ACC_WIDTH = 128;
    localparam int DEF_SHIFT_W   = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int MAX_ACC_WIDTH = 1024;

    function automatic int slot_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Limits are built at the widest supported size; callers truncate to ACC_WIDTH.
    function automatic logic [MAX_ACC_WIDTH-1:0] acc_max(input int w);
        return (MAX_ACC_WIDTH'(1) << (w - 1)) - MAX_ACC_WIDTH'(1);
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] acc_min(input int w);
        return MAX_ACC_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/acc_shift_stage.sv
// acc_shift_stage: registered barrel shifter with shift-overflow detection (S1)
//   in_valid/in_data/in_shift/in_sign/in_slot : accepted beat
//   s1_valid/s1_val/s1_ovf/s1_sign/s1_slot    : registered shifted beat
module acc_shift_stage
    import shift_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int SLOT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [SHIFT_W-1:0]   in_shift,
    input  logic                 in_sign,
    input  logic [SLOT_W-1:0]    in_slot,
    output logic                 s1_valid,
    output logic [ACC_WIDTH-1:0] s1_val,
    output logic                 s1_ovf,
    output logic                 s1_sign,
    output logic [SLOT_W-1:0]    s1_slot
);

    logic [ACC_WIDTH-1:0] sh_val;
    logic                 sh_ovf;

    // Overflow when any set data bit lands at or above the accumulator sign bit.
    always_comb begin
        sh_val = ACC_WIDTH'(in_data) << in_shift;
        sh_ovf = (32'(in_shift) >= ACC_WIDTH - 1) ? |in_data
                                                 : |(in_data >> (ACC_WIDTH - 1 - 32'(in_shift)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_ovf   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_slot  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_val   <= sh_val;
            s1_ovf   <= sh_ovf;
            s1_sign  <= in_sign;
            s1_slot  <= in_slot;
        end
    end

endmodule

// File: rtl/shift_acc_mc.sv
// shift_acc_mc: multi-slot shift-accumulator with per-slot sticky overflow and drain-on-clear
//   in_*  : beat stream (magnitude, shift, sign, slot); in_tready high once out of reset
//   clr_* : drain request for one slot; clr_ready is the combinational accept
//   add_valid : high in the cycle before a beat commits into its slot
//   res_* : drained slot value, index and overflow flag, held until res_tready
module shift_acc_mc
    import shift_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SATURATE  = 0,
    localparam int SLOT_W   = slot_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic [IN_WIDTH-1:0]  in_tdata,
    input  logic [SHIFT_W-1:0]   in_shift,
    input  logic                 in_sign,
    input  logic [SLOT_W-1:0]    in_slot,
    input  logic                 clr_valid,
    output logic                 clr_ready,
    input  logic [SLOT_W-1:0]    clr_slot,
    output logic                 add_valid,
    output logic                 res_tvalid,
    input  logic                 res_tready,
    output logic [ACC_WIDTH-1:0] res_tdata,
    output logic [SLOT_W-1:0]    res_tuser,
    output logic                 res_ovf
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic                 rstn_q;
    logic                 in_fire, clr_fire, clr_in_range;
    logic                 s1_valid, s1_ovf, s1_sign;
    logic [ACC_WIDTH-1:0] s1_val;
    logic [SLOT_W-1:0]    s1_slot;
    logic                 s2_valid, s2_ovf, s2_sign;
    logic [ACC_WIDTH-1:0] s2_val;
    logic [SLOT_W-1:0]    s2_slot;
    logic [ACC_WIDTH-1:0] acc [DEPTH];
    logic [DEPTH-1:0]     ovf;
    logic [ACC_WIDTH-1:0] cur, nxt;
    logic [ACC_WIDTH:0]   sum;
    logic                 any_ovf;

    assign in_tready    = rstn_q;
    assign add_valid    = s2_valid;
    // Beats to nonexistent slots are dropped before entering the pipeline.
    assign in_fire      = in_tvalid && rstn_q && (32'(in_slot) < DEPTH);
    assign clr_in_range = 32'(clr_slot) < DEPTH;
    // A clear waits until no in-flight beat targets its slot, so it never races a commit.
    assign clr_ready    = rstn_q && !(s1_valid && s1_slot == clr_slot)
                                 && !(s2_valid && s2_slot == clr_slot)
                                 && (!res_tvalid || res_tready);
    assign clr_fire     = clr_valid && clr_ready;

    acc_shift_stage #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .SHIFT_W  (SHIFT_W),
        .SLOT_W   (SLOT_W)
    ) u_s1 (
        .clk     (clk),
        .rstn    (rstn),
        .in_valid(in_fire),
        .in_data (in_tdata),
        .in_shift(in_shift),
        .in_sign (in_sign),
        .in_slot (in_slot),
        .s1_valid(s1_valid),
        .s1_val  (s1_val),
        .s1_ovf  (s1_ovf),
        .s1_sign (s1_sign),
        .s1_slot (s1_slot)
    );

    // One extra guard bit exposes signed overflow as a mismatch of the top two sum bits.
    always_comb begin
        cur     = acc[s2_slot];
        sum     = s2_sign ? {cur[ACC_WIDTH-1], cur} - {1'b0, s2_val}
                          : {cur[ACC_WIDTH-1], cur} + {1'b0, s2_val};
        any_ovf = (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) | s2_ovf;
        nxt     = (SATURATE != 0 && any_ovf) ? (s2_sign ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstn_q     <= 1'b0;
            s2_valid   <= 1'b0;
            s2_val     <= '0;
            s2_ovf     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_slot    <= '0;
            res_tvalid <= 1'b0;
            res_tdata  <= '0;
            res_tuser  <= '0;
            res_ovf    <= 1'b0;
            ovf        <= '0;
            for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
        end else begin
            rstn_q   <= 1'b1;
            s2_valid <= s1_valid;
            s2_val   <= s1_val;
            s2_ovf   <= s1_ovf;
            s2_sign  <= s1_sign;
            s2_slot  <= s1_slot;
            if (s2_valid) begin
                acc[s2_slot] <= nxt;
                if (any_ovf) ovf[s2_slot] <= 1'b1;
            end
            if (clr_fire) begin
                res_tvalid <= 1'b1;
                res_tdata  <= clr_in_range ? acc[clr_slot] : '0;
                res_tuser  <= clr_slot;
                res_ovf    <= clr_in_range ? ovf[clr_slot] : 1'b1;
                if (clr_in_range) begin
                    acc[clr_slot] <= '0;
                    ovf[clr_slot] <= 1'b0;
                end
            end else if (res_tready) begin
                res_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_acc_mc.sv
// tb_shift_acc_mc: directed checks of shift_acc_mc in wrap and saturate configurations
module tb_shift_acc_mc;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_tvalid, in_sign, clr_valid, res_tready;
    logic [63:0]  in_tdata;
    logic [7:0]   in_shift;
    logic [4:0]   in_slot, clr_slot;

    logic         w_in_tready, w_clr_ready, w_add_valid, w_res_tvalid, w_res_ovf;
    logic [127:0] w_res_tdata;
    logic [4:0]   w_res_tuser;
    logic         s_in_tready, s_clr_ready, s_add_valid, s_res_tvalid, s_res_ovf;
    logic [127:0] s_res_tdata;
    logic [4:0]   s_res_tuser;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] MAX_POS = {1'b0, {127{1'b1}}};
    localparam logic [127:0] MIN_NEG = {1'b1, {127{1'b0}}};

    always #5 clk = ~clk;

    shift_acc_mc #(.SATURATE(0)) u_wrap (
        .clk(clk), .rstn(rstn),
        .in_tvalid(in_tvalid), .in_tready(w_in_tready), .in_tdata(in_tdata),
        .in_shift(in_shift), .in_sign(in_sign), .in_slot(in_slot),
        .clr_valid(clr_valid), .clr_ready(w_clr_ready), .clr_slot(clr_slot),
        .add_valid(w_add_valid),
        .res_tvalid(w_res_tvalid), .res_tready(res_tready), .res_tdata(w_res_tdata),
        .res_tuser(w_res_tuser), .res_ovf(w_res_ovf)
    );

    shift_acc_mc #(.SATURATE(1)) u_sat (
        .clk(clk), .rstn(rstn),
        .in_tvalid(in_tvalid), .in_tready(s_in_tready), .in_tdata(in_tdata),
        .in_shift(in_shift), .in_sign(in_sign), .in_slot(in_slot),
        .clr_valid(clr_valid), .clr_ready(s_clr_ready), .clr_slot(clr_slot),
        .add_valid(s_add_valid),
        .res_tvalid(s_res_tvalid), .res_tready(res_tready), .res_tdata(s_res_tdata),
        .res_tuser(s_res_tuser), .res_ovf(s_res_ovf)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [4:0] s, input logic [63:0] d, input logic [7:0] sh, input logic sg);
        in_tvalid = 1'b1; in_slot = s; in_tdata = d; in_shift = sh; in_sign = sg;
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic do_clear(input logic [4:0] s);
        int waited;
        waited = 0;
        clr_valid = 1'b1; clr_slot = s;
        #1;
        while (!w_clr_ready && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (waited == 20) check("clr_timeout", 128'(w_clr_ready), 128'd1);
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
    endtask

    task automatic clear_check(input string tag, input logic [4:0] s, input logic [127:0] d, input logic o);
        do_clear(s);
        check({tag, "_valid"}, 128'(w_res_tvalid), 128'd1);
        check({tag, "_data"}, w_res_tdata, d);
        check({tag, "_user"}, 128'(w_res_tuser), 128'(s));
        check({tag, "_ovf"}, 128'(w_res_ovf), 128'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; in_tvalid = 1'b0; in_sign = 1'b0; in_tdata = '0; in_shift = '0;
        in_slot = '0; clr_valid = 1'b0; clr_slot = '0; res_tready = 1'b1;
        #3;
        check("rst_in_tready", 128'(w_in_tready), 128'd0);
        check("rst_clr_ready", 128'(w_clr_ready), 128'd0);
        check("rst_res_tvalid", 128'(w_res_tvalid), 128'd0);
        check("rst_res_tdata", w_res_tdata, 128'd0);
        check("rst_add_valid", 128'(w_add_valid), 128'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("rel_in_tready_low", 128'(w_in_tready), 128'd0);
        idle(1);
        check("rel_in_tready_high", 128'(w_in_tready), 128'd1);

        // 5<<4 = 80, minus 3 = 77
        beat(5'd3, 64'd5, 8'd4, 1'b0);
        check("s1_no_add_valid", 128'(w_add_valid), 128'd0);
        beat(5'd3, 64'd3, 8'd0, 1'b1);
        check("s2_add_valid", 128'(w_add_valid), 128'd1);
        idle(3);
        check("idle_add_valid", 128'(w_add_valid), 128'd0);
        clear_check("slot3", 5'd3, 128'd77, 1'b0);
        clear_check("slot3_again", 5'd3, 128'd0, 1'b0);

        // hazard: clear of slot 5 waits for the in-flight beat to commit
        idle(2);
        beat(5'd5, 64'd1, 8'd0, 1'b0);
        clr_valid = 1'b1; clr_slot = 5'd5;
        #1;
        check("hz_t1_clr_ready", 128'(w_clr_ready), 128'd0);
        idle(1);
        check("hz_t2_clr_ready", 128'(w_clr_ready), 128'd0);
        check("hz_t2_add_valid", 128'(w_add_valid), 128'd1);
        idle(1);
        check("hz_t3_clr_ready", 128'(w_clr_ready), 128'd1);
        idle(1);
        clr_valid = 1'b0;
        check("hz_res_tdata", w_res_tdata, 128'd1);
        check("hz_res_tuser", 128'(w_res_tuser), 128'd5);

        // beat and clear to the same slot in the same cycle: beat lands after the clear
        beat(5'd7, 64'd10, 8'd0, 1'b0);
        idle(3);
        in_tvalid = 1'b1; in_slot = 5'd7; in_tdata = 64'd2; in_shift = 8'd0; in_sign = 1'b0;
        clr_valid = 1'b1; clr_slot = 5'd7;
        #1;
        check("same_clr_ready", 128'(w_clr_ready), 128'd1);
        idle(1);
        in_tvalid = 1'b0; clr_valid = 1'b0;
        check("same_res_tdata", w_res_tdata, 128'd10);
        idle(3);
        clear_check("same_after", 5'd7, 128'd2, 1'b0);

        // 2^126 + 2^126 overflows the signed range
        beat(5'd9, 64'd1, 8'd126, 1'b0);
        beat(5'd9, 64'd1, 8'd126, 1'b0);
        idle(3);
        clear_check("wrap", 5'd9, MIN_NEG, 1'b1);
        check("sat_data", s_res_tdata, MAX_POS);
        check("sat_ovf", 128'(s_res_ovf), 128'd1);

        // oversized shift of nonzero data flags overflow without changing the slot
        beat(5'd11, 64'd1, 8'd200, 1'b0);
        idle(3);
        clear_check("shift200", 5'd11, 128'd0, 1'b1);
        beat(5'd12, 64'd0, 8'd200, 1'b0);
        idle(3);
        clear_check("shift200_zero", 5'd12, 128'd0, 1'b0);

        // result backpressure
        beat(5'd13, 64'd4, 8'd0, 1'b0);
        beat(5'd14, 64'd6, 8'd0, 1'b0);
        idle(3);
        res_tready = 1'b0;
        clear_check("stall_first", 5'd13, 128'd4, 1'b0);
        clr_valid = 1'b1; clr_slot = 5'd14;
        #1;
        check("stall_clr_ready", 128'(w_clr_ready), 128'd0);
        idle(2);
        check("stall_clr_ready_hold", 128'(w_clr_ready), 128'd0);
        check("stall_tvalid_hold", 128'(w_res_tvalid), 128'd1);
        check("stall_tdata_hold", w_res_tdata, 128'd4);
        check("stall_tuser_hold", 128'(w_res_tuser), 128'd13);
        res_tready = 1'b1;
        #1;
        check("unstall_clr_ready", 128'(w_clr_ready), 128'd1);
        idle(1);
        clr_valid = 1'b0;
        check("unstall_tdata", w_res_tdata, 128'd6);
        check("unstall_tuser", 128'(w_res_tuser), 128'd14);

        // reset with beats in flight and a pending result
        beat(5'd22, 64'd9, 8'd0, 1'b0);
        idle(3);
        res_tready = 1'b0;
        do_clear(5'd22);
        beat(5'd20, 64'd1, 8'd0, 1'b0);
        beat(5'd21, 64'd1, 8'd0, 1'b0);
        check("pre_rst_tvalid", 128'(w_res_tvalid), 128'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tvalid", 128'(w_res_tvalid), 128'd0);
        check("mid_rst_tdata", w_res_tdata, 128'd0);
        check("mid_rst_add_valid", 128'(w_add_valid), 128'd0);
        check("mid_rst_in_tready", 128'(w_in_tready), 128'd0);
        check("mid_rst_clr_ready", 128'(w_clr_ready), 128'd0);
        check("mid_rst_ovf", 128'(w_res_ovf), 128'd0);
        idle(1);
        rstn = 1'b1;
        res_tready = 1'b1;
        idle(4);
        clear_check("post_rst20", 5'd20, 128'd0, 1'b0);
        clear_check("post_rst21", 5'd21, 128'd0, 1'b0);
        clear_check("post_rst22", 5'd22, 128'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
